// File: rtl/mod_counter_pkg.sv
// Shared types and helpers for the modulo up/down counter.
package mod_counter_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  // Highest count value reachable for a given modulus.
  function automatic longint unsigned limit_of(input longint unsigned modulus);
    return modulus - 64'd1;
  endfunction

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-count, load clamp, terminal count and terminal-step flag.
module mod_counter_next
  import mod_counter_pkg::*;
#(
  parameter int unsigned    WIDTH = 4,
  parameter logic [WIDTH:0] LIMIT = {1'b0, {WIDTH{1'b1}}}
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_en,
  input  logic             i_up,
  input  mode_e            i_mode,
  output logic [WIDTH-1:0] o_q_next,
  output logic [WIDTH-1:0] o_load_val,
  output logic             o_tc,
  output logic             o_term
);

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] w_q_ext;
  logic [WIDTH:0] w_din_ext;
  logic           w_at_limit;

  // One extra bit keeps q+1 from truncating when MODULUS = 2**WIDTH.
  assign w_q_ext    = {1'b0, i_q};
  assign w_din_ext  = {1'b0, i_din};
  assign w_at_limit = i_up ? (w_q_ext == LIMIT) : (w_q_ext == '0);

  assign o_term = i_en & w_at_limit;
  assign o_tc   = o_term;

  assign o_load_val = (w_din_ext > LIMIT) ? WIDTH'(LIMIT) : i_din;

  always_comb begin
    // NOTE: default first so every path assigns o_q_next and no latch is inferred.
    o_q_next = i_q;
    if (w_at_limit) begin
      if (i_mode == MODE_WRAP) begin
        o_q_next = i_up ? '0 : WIDTH'(LIMIT);
      end
    end else if (i_up) begin
      o_q_next = WIDTH'(w_q_ext + ONE);
    end else begin
      o_q_next = WIDTH'(w_q_ext - ONE);
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Modulo up/down counter with load, clear, wrap/saturate mode and sticky overflow.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int unsigned     WIDTH       = 4,
  parameter longint unsigned MODULUS     = 64'd1 << WIDTH,
  parameter bit              SAT_DEFAULT = 1'b0
) (
  input  logic             elk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             up,
  input  logic             sat,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  if (WIDTH < 2 || WIDTH > 32 || MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_params
    $error("mod_counter: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
  end

  localparam logic [WIDTH:0] LIMIT     = (WIDTH + 1)'(limit_of(MODULUS));
  localparam mode_e          MODE_INIT = SAT_DEFAULT ? MODE_SAT : MODE_WRAP;

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;
  mode_e            r_mode;

  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_load_val;
  logic             w_term;
  logic             w_ovf_set;

  mod_counter_next #(
    .WIDTH (WIDTH),
    .LIMIT (LIMIT)
  ) u_next (
    .i_q        (r_q),
    .i_din      (din),
    .i_en       (en),
    .i_up       (up),
    .i_mode     (r_mode),
    .o_q_next   (w_q_next),
    .o_load_val (w_load_val),
    .o_tc       (tc),
    .o_term     (w_term)
  );

  // A terminal step only counts when clear and load do not pre-empt it.
  assign w_ovf_set = w_term & ~clr & ~load;

  always_ff @(negedge elk or posedge reset) begin
    if (reset) begin
      r_q    <= '0;
      r_ovf  <= 1'b0;
      r_mode <= MODE_INIT;
    end else begin
      // NOTE: non-blocking so all three registers update from the same pre-edge values.
      r_mode <= sat ? MODE_SAT : MODE_WRAP;

      if (clr) begin
        r_q <= '0;
      end else if (load) begin
        r_q <= w_load_val;
      end else if (en) begin
        r_q <= w_q_next;
      end

      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign q   = r_q;
  assign ovf = r_ovf;

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench: MODULUS=10 instance and default-parameter instance on shared stimulus.
module tb_mod_counter;

  logic       elk = 1'b0;
  logic       reset;
  logic       en, clr, load, up, sat, ovf_clr;
  logic [3:0] din;
  logic [3:0] q10, q16;
  logic       tc10, tc16, ovf10, ovf16;

  int total = 0;
  int bad   = 0;

  always #5 elk = ~elk;

  mod_counter #(.WIDTH(4), .MODULUS(10)) u_dut10 (
    .elk(elk), .reset(reset), .en(en), .clr(clr), .load(load), .din(din),
    .up(up), .sat(sat), .ovf_clr(ovf_clr), .q(q10), .tc(tc10), .ovf(ovf10)
  );

  mod_counter u_dut16 (
    .elk(elk), .reset(reset), .en(en), .clr(clr), .load(load), .din(din),
    .up(up), .sat(sat), .ovf_clr(ovf_clr), .q(q16), .tc(tc16), .ovf(ovf16)
  );

  // Advance past the next active (falling) edge; inputs change and outputs are sampled here.
  task automatic step();
    @(negedge elk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 0; clr = 0; load = 0; up = 0; ovf_clr = 0; din = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; sat = 1'b0;
    idle_inputs();
    #1;
    total++; if (q10 !== 4'd0)  begin bad++; $display("FAIL reset_q got=%0d want=0", q10); end
    total++; if (ovf10 !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b want=0", ovf10); end
    total++; if (tc10 !== 1'b0) begin bad++; $display("FAIL reset_tc_en0 got=%0b want=0", tc10); end
    en = 1; up = 0; #1;
    total++; if (tc10 !== 1'b1) begin bad++; $display("FAIL reset_tc_down got=%0b want=1", tc10); end
    total++; if (tc16 !== 1'b1) begin bad++; $display("FAIL reset_tc16_down got=%0b want=1", tc16); end
    up = 1; #1;
    total++; if (tc10 !== 1'b0) begin bad++; $display("FAIL reset_tc_up got=%0b want=0", tc10); end
    idle_inputs();
    reset = 1'b0;
    step();
    total++; if (q10 !== 4'd0) begin bad++; $display("FAIL reset_hold_q got=%0d want=0", q10); end
  endtask

  task automatic test_wrap_up();
    logic [3:0] exp_q;
    logic       exp_ovf, exp_tc;
    clr = 1; ovf_clr = 1; sat = 0;
    step();
    idle_inputs();
    en = 1; up = 1;
    exp_q = 4'd0;
    for (int i = 1; i <= 12; i++) begin
      #1;
      exp_tc = (exp_q == 4'd9);
      total++; if (tc10 !== exp_tc) begin bad++; $display("FAIL wrap_up_tc[%0d] got=%0b want=%0b", i, tc10, exp_tc); end
      step();
      exp_q   = 4'(i % 10);
      exp_ovf = (i >= 10);
      total++; if (q10 !== exp_q) begin bad++; $display("FAIL wrap_up_q[%0d] got=%0d want=%0d", i, q10, exp_q); end
      total++; if (ovf10 !== exp_ovf) begin bad++; $display("FAIL wrap_up_ovf[%0d] got=%0b want=%0b", i, ovf10, exp_ovf); end
    end
    idle_inputs();
  endtask

  task automatic test_sat_down();
    logic [3:0] exp_q  [4] = '{4'd1, 4'd0, 4'd0, 4'd0};
    logic       exp_ovf[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       exp_tc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    sat = 1; load = 1; din = 4'd2; ovf_clr = 1;
    step();
    total++; if (q10 !== 4'd2)   begin bad++; $display("FAIL sat_down_load got=%0d want=2", q10); end
    total++; if (ovf10 !== 1'b0) begin bad++; $display("FAIL sat_down_ovfclr got=%0b want=0", ovf10); end
    idle_inputs();
    en = 1; up = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (tc10 !== exp_tc[i]) begin bad++; $display("FAIL sat_down_tc[%0d] got=%0b want=%0b", i, tc10, exp_tc[i]); end
      step();
      total++; if (q10 !== exp_q[i]) begin bad++; $display("FAIL sat_down_q[%0d] got=%0d want=%0d", i, q10, exp_q[i]); end
      total++; if (ovf10 !== exp_ovf[i]) begin bad++; $display("FAIL sat_down_ovf[%0d] got=%0b want=%0b", i, ovf10, exp_ovf[i]); end
    end
    idle_inputs();
  endtask

  task automatic test_load();
    logic [3:0] dins[5]  = '{4'd13, 4'd10, 4'd9, 4'd3, 4'd15};
    logic [3:0] exp10[5] = '{4'd9,  4'd9,  4'd9, 4'd3, 4'd9};
    sat = 0;
    for (int i = 0; i < 5; i++) begin
      load = 1; din = dins[i]; en = 1; up = 1;
      step();
      total++; if (q10 !== exp10[i]) begin bad++; $display("FAIL load10[%0d] got=%0d want=%0d", i, q10, exp10[i]); end
      total++; if (q16 !== dins[i]) begin bad++; $display("FAIL load16[%0d] got=%0d want=%0d", i, q16, dins[i]); end
    end
    load = 1; clr = 1; din = 4'd5;
    step();
    total++; if (q10 !== 4'd0) begin bad++; $display("FAIL load_clr10 got=%0d want=0", q10); end
    total++; if (q16 !== 4'd0) begin bad++; $display("FAIL load_clr16 got=%0d want=0", q16); end
    idle_inputs();
  endtask

  task automatic test_set_wins();
    sat = 0; load = 1; din = 4'd15; ovf_clr = 1;
    step();
    total++; if (q16 !== 4'd15)  begin bad++; $display("FAIL setwins_load got=%0d want=15", q16); end
    total++; if (ovf16 !== 1'b0) begin bad++; $display("FAIL setwins_pre_ovf got=%0b want=0", ovf16); end
    load = 0; en = 1; up = 1; ovf_clr = 1;
    #1;
    total++; if (tc16 !== 1'b1) begin bad++; $display("FAIL setwins_tc got=%0b want=1", tc16); end
    step();
    total++; if (q16 !== 4'd0)   begin bad++; $display("FAIL setwins_q got=%0d want=0", q16); end
    total++; if (ovf16 !== 1'b1) begin bad++; $display("FAIL setwins_ovf got=%0b want=1", ovf16); end
    en = 0; ovf_clr = 1;
    step();
    total++; if (ovf16 !== 1'b0) begin bad++; $display("FAIL ovfclr_only got=%0b want=0", ovf16); end
    idle_inputs();
  endtask

  task automatic test_wrap_down();
    clr = 1; ovf_clr = 1; sat = 0;
    step();
    idle_inputs();
    en = 1; up = 0;
    #1;
    total++; if (tc10 !== 1'b1) begin bad++; $display("FAIL wrap_down_tc got=%0b want=1", tc10); end
    step();
    total++; if (q10 !== 4'd9)   begin bad++; $display("FAIL wrap_down_q got=%0d want=9", q10); end
    total++; if (ovf10 !== 1'b1) begin bad++; $display("FAIL wrap_down_ovf got=%0b want=1", ovf10); end
    step();
    total++; if (q10 !== 4'd8) begin bad++; $display("FAIL wrap_down_dec got=%0d want=8", q10); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    load = 1; din = 4'd7;
    step();
    total++; if (q10 !== 4'd7)   begin bad++; $display("FAIL rstmid_pre_q got=%0d want=7", q10); end
    total++; if (ovf10 !== 1'b1) begin bad++; $display("FAIL rstmid_pre_ovf got=%0b want=1", ovf10); end
    idle_inputs();
    #2 reset = 1'b1;
    #1;
    total++; if (q10 !== 4'd0)   begin bad++; $display("FAIL rstmid_q got=%0d want=0", q10); end
    total++; if (ovf10 !== 1'b0) begin bad++; $display("FAIL rstmid_ovf got=%0b want=0", ovf10); end
    reset = 1'b0;
    en = 1; up = 1;
    step();
    total++; if (q10 !== 4'd1) begin bad++; $display("FAIL rstmid_resume got=%0d want=1", q10); end
    idle_inputs();
  endtask

  task automatic test_hold();
    load = 1; din = 4'd9; en = 1; up = 1;
    step();
    load = 0;
    step();
    load = 1; din = 4'd5; en = 0;
    step();
    total++; if (q10 !== 4'd5)   begin bad++; $display("FAIL hold_pre_q got=%0d want=5", q10); end
    total++; if (ovf10 !== 1'b1) begin bad++; $display("FAIL hold_pre_ovf got=%0b want=1", ovf10); end
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      up = i[0];
      #1;
      total++; if (tc10 !== 1'b0) begin bad++; $display("FAIL hold_tc[%0d] got=%0b want=0", i, tc10); end
      step();
      total++; if (q10 !== 4'd5)   begin bad++; $display("FAIL hold_q[%0d] got=%0d want=5", i, q10); end
      total++; if (ovf10 !== 1'b1) begin bad++; $display("FAIL hold_ovf[%0d] got=%0b want=1", i, ovf10); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_load();
    test_set_wins();
    test_wrap_down();
    test_reset_mid();
    test_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
